dct_block_ctrl: RTL and testbench
=================================

Name: dct_block_ctrl

Overview:
- Sequencing controller for the 2-D 8x8 DCT pipeline: row-stage DCT → ping-pong transpose memory pair → column-stage DCT.
- Tracks ownership of the two transpose banks as a 2-entry block FIFO, with valid/ready handshakes on both sides.
- Generates the bank write/read enables and row addresses, the column-stage DC-control strobe, and block counters.
- Replaces the free-running cnt_in-decode sequencing, so the pipeline tolerates input gaps and output backpressure.

Parameters:
- ROWS, 8, rows per block; must be a power of two.
- ROW_W, 3, log2(ROWS); row address width.
- CNT_W, 15, width of the block counters.

Ports:
- clk  input  1  clock, rising-edge.
- reset  input  1  asynchronous, active-low reset.
- en  input  1  accept enable; 0 blocks new input rows, draining continues.
- in_valid  input  1  row-stage output row is valid this cycle.
- in_ready  output  1  controller accepts a row this cycle.
- tp_wr_en  output  2  one-hot write enable, bank0/bank1.
- tp_wr_addr  output  ROW_W  row index being written.
- out_valid  output  1  column-stage data is valid (read bank full).
- out_ready  input  1  downstream accepts a row.
- tp_rd_en  output  2  one-hot read-advance enable.
- tp_rd_addr  output  ROW_W  row index being read; combinational read address to the bank.
- dc_en  output  1  column-stage DC control strobe.
- out_last  output  1  last row of the block is on the output.
- blk_cnt_in  output  CNT_W  count of blocks fully written.
- blk_cnt_out  output  CNT_W  count of blocks fully read.
- status  output  2  00 = both banks empty, 01 = one bank full, 10 = both full.

Behaviour:
Registered state (all cleared asynchronously while reset = 0):
- wr_bank, rd_bank, bank_full[1:0], wr_ptr, rd_ptr, blk_cnt_in, blk_cnt_out.
- Consequence at reset: in_ready = en, out_valid = 0, tp_wr_en = 0, tp_rd_en = 0, dc_en = 0, out_last = 0, status = 00, both counters = 0.

Write side:
- in_ready = en & ~bank_full[wr_bank], combinational.
- Write handshake = in_valid & in_ready.
- tp_wr_en[wr_bank] = write handshake; tp_wr_addr = wr_ptr.
- Each handshake increments wr_ptr.
- On the handshake with wr_ptr = ROWS-1: wr_ptr wraps to 0, bank_full[wr_bank] is set, wr_bank toggles, blk_cnt_in increments.

Read side:
- out_valid = bank_full[rd_bank].
- tp_rd_en[rd_bank] = out_valid & out_ready; tp_rd_addr = rd_ptr.
- Each read handshake increments rd_ptr.
- On the read handshake with rd_ptr = ROWS-1: rd_ptr wraps to 0, bank_full[rd_bank] is cleared, rd_bank toggles, blk_cnt_out increments.
- dc_en = out_valid & (rd_ptr == 0).
- out_last = out_valid & (rd_ptr == ROWS-1).

Latency and throughput:
- out_valid rises 1 cycle after the handshake that completes a block.
- With in_valid and out_ready held high, throughput is 1 row/cycle sustained, with no bubble at bank swaps.

Boundary conditions:
- Simultaneous final write and final read touch different banks; both updates apply in the same edge.
- Both banks full: in_ready = 0 until a final read handshake; in_ready rises in the cycle after that edge.
- out_ready low: rd_ptr and all outputs hold; dc_en and out_last stay asserted while stalled on their row.
- en deasserted mid-block: wr_ptr holds and the partial block is kept; writing resumes at the same row.
- Reset mid-operation discards partial and full blocks; counters restart at 0.
- Block counters wrap modulo 2^CNT_W.
- tp_wr_en and tp_rd_en are never both high for the same bank.

Optional Feature:
- Macro: DCT_BLOCK_CTRL_STATS_EN.
- Defined: adds output stall_cnt [15:0] and output ovf_flag [0:0].
  - stall_cnt increments each cycle with out_valid & ~out_ready and saturates at 16'hFFFF.
  - ovf_flag is sticky; it is set each cycle in_valid & ~in_ready & en.
  - Both cleared only by reset.
- Not defined: neither port exists and no associated logic is present.

Decomposition:
- Shared package dct_pkg:
  - constants DCT_ROWS = 8, DCT_ROW_W = 3, DCT_CNT_W = 15;
  - 2-bit status encodings ST_EMPTY, ST_HALF, ST_FULL.
- One natural sub-module, dct_row_ptr: a ROW_W wrap counter with advance input and wrap pulse.
  - Instantiated twice, once for the write side and once for the read side.

Test Plan:
1. Reset, then 16 rows with in_valid = 1, out_ready = 1 → tp_wr_en = 01 for rows 0–7 and 10 for rows 8–15. out_valid is first high on cycle 9 with dc_en = 1 and tp_rd_addr = 0. blk_cnt_out = 2 after 24 cycles.
2. out_ready = 0, stream 20 rows → in_ready drops after row 16 and status = 10. Then out_ready = 1 for one cycle at rd_ptr = 7 with rd_ptr forced → in_ready = 1 the next cycle.
3. Continuous streaming of 64 rows with out_ready toggling every cycle → no row lost or duplicated; blk_cnt_in = 8 and blk_cnt_out = 8 at the end.
4. en = 0 after 3 rows for 5 cycles → tp_wr_addr = 3 on resume and out_valid stays 0 until 5 more rows are written.
5. Assert reset for 1 cycle mid-block, at wr_ptr = 5 with one bank full → all outputs return to reset values immediately; status = 00.
6. With DCT_BLOCK_CTRL_STATS_EN defined: hold out_ready = 0 for 10 cycles while out_valid = 1 → stall_cnt = 10. Drive in_valid while full → ovf_flag = 1 and remains set.

Source files
------------

// File: rtl/dct_pkg.sv
// Shared constants and types for the 8x8 DCT block sequencing controller.
package dct_pkg;

  localparam int unsigned DCT_ROWS  = 8;
  localparam int unsigned DCT_ROW_W = 3;
  localparam int unsigned DCT_CNT_W = 15;

  // Occupancy of the two-entry transpose bank FIFO
  typedef enum logic [1:0] {
    ST_EMPTY = 2'b00,
    ST_HALF  = 2'b01,
    ST_FULL  = 2'b10
  } dct_status_e;

  typedef enum logic {
    BANK0 = 1'b0,
    BANK1 = 1'b1
  } dct_bank_e;

  function automatic dct_status_e status_of(input logic [1:0] full);
    case (full)
      2'b00:   return ST_EMPTY;
      2'b11:   return ST_FULL;
      default: return ST_HALF;
    endcase
  endfunction

  function automatic logic [1:0] bank_onehot(input dct_bank_e bank);
    return (bank == BANK1) ? 2'b10 : 2'b01;
  endfunction

  function automatic dct_bank_e other_bank(input dct_bank_e bank);
    return (bank == BANK1) ? BANK0 : BANK1;
  endfunction

endpackage

// File: rtl/dct_row_ptr.sv
// Row index wrap counter: advances on adv, pulses wrap on the advance from the last row.
module dct_row_ptr #(
  parameter int unsigned W = 3
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         adv,
  output logic [W-1:0] ptr,
  output logic         wrap
);

  localparam logic [W-1:0] ONE = 1;

  // Row count is a power of two, so the last row is the all-ones index
  assign wrap = adv & (ptr == '1);

  // Pointer register; rolls over naturally to 0 after the last row
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)   ptr <= '0;
    else if (adv) ptr <= ptr + ONE;
  end

endmodule

// File: rtl/dct_block_ctrl.sv
// Ping-pong transpose bank sequencer between row and column DCT stages.
// Optional statistics outputs enabled by defining DCT_BLOCK_CTRL_STATS_EN.
module dct_block_ctrl
  import dct_pkg::*;
#(
  parameter int unsigned ROWS  = DCT_ROWS,
  parameter int unsigned ROW_W = DCT_ROW_W,
  parameter int unsigned CNT_W = DCT_CNT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [1:0]       tp_wr_en,
  output logic [ROW_W-1:0] tp_wr_addr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [1:0]       tp_rd_en,
  output logic [ROW_W-1:0] tp_rd_addr,
  output logic             dc_en,
  output logic             out_last,
  output logic [CNT_W-1:0] blk_cnt_in,
  output logic [CNT_W-1:0] blk_cnt_out,
  output logic [1:0]       status
`ifdef DCT_BLOCK_CTRL_STATS_EN
  ,
  output logic [15:0]      stall_cnt,
  output logic [0:0]       ovf_flag
`endif
);

  localparam logic [CNT_W-1:0] CNT_ONE  = 1;
  localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(ROWS - 1);

  dct_bank_e  wr_bank, rd_bank;
  logic [1:0] bank_full, bank_full_nxt;
  logic       wr_hs, rd_hs, wr_wrap, rd_wrap;

  assign in_ready  = en & ~bank_full[wr_bank];
  assign wr_hs     = in_valid & in_ready;
  assign out_valid = bank_full[rd_bank];
  assign rd_hs     = out_valid & out_ready;

  assign tp_wr_en  = wr_hs ? bank_onehot(wr_bank) : 2'b00;
  assign tp_rd_en  = rd_hs ? bank_onehot(rd_bank) : 2'b00;
  assign dc_en     = out_valid & (tp_rd_addr == '0);
  assign out_last  = out_valid & (tp_rd_addr == LAST_ROW);
  assign status    = status_of(bank_full);

  dct_row_ptr #(.W(ROW_W)) u_wr_ptr (
    .clk(clk), .reset(reset), .adv(wr_hs), .ptr(tp_wr_addr), .wrap(wr_wrap)
  );

  dct_row_ptr #(.W(ROW_W)) u_rd_ptr (
    .clk(clk), .reset(reset), .adv(rd_hs), .ptr(tp_rd_addr), .wrap(rd_wrap)
  );

  // Bank occupancy update; a completing write and a completing read always
  // target different banks, so both edits can apply in the same cycle
  always_comb begin
    bank_full_nxt = bank_full;
    if (wr_wrap) bank_full_nxt[wr_bank] = 1'b1;
    if (rd_wrap) bank_full_nxt[rd_bank] = 1'b0;
  end

  // Bank ownership, occupancy and block counters
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_bank     <= BANK0;
      rd_bank     <= BANK0;
      bank_full   <= '0;
      blk_cnt_in  <= '0;
      blk_cnt_out <= '0;
    end else begin
      bank_full <= bank_full_nxt;
      if (wr_wrap) begin
        wr_bank    <= other_bank(wr_bank);
        blk_cnt_in <= blk_cnt_in + CNT_ONE;
      end
      if (rd_wrap) begin
        rd_bank     <= other_bank(rd_bank);
        blk_cnt_out <= blk_cnt_out + CNT_ONE;
      end
    end
  end

`ifdef DCT_BLOCK_CTRL_STATS_EN
  // Saturating output-stall counter and sticky input-overflow flag
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cnt <= '0;
      ovf_flag  <= '0;
    end else begin
      if (out_valid && !out_ready && (stall_cnt != '1)) stall_cnt <= stall_cnt + 16'd1;
      if (in_valid && !in_ready && en) ovf_flag <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_dct_block_ctrl.sv
// Directed self-checking bench for dct_block_ctrl.
module tb_dct_block_ctrl;

  logic        clk = 1'b0;
  logic        reset, en, in_valid, out_ready;
  logic        in_ready, out_valid, dc_en, out_last;
  logic [1:0]  tp_wr_en, tp_rd_en, status;
  logic [2:0]  tp_wr_addr, tp_rd_addr;
  logic [14:0] blk_cnt_in, blk_cnt_out;
`ifdef DCT_BLOCK_CTRL_STATS_EN
  logic [15:0] stall_cnt;
  logic [0:0]  ovf_flag;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  dct_block_ctrl #(.ROWS(8), .ROW_W(3), .CNT_W(15)) dut (
    .clk(clk), .reset(reset), .en(en), .in_valid(in_valid), .in_ready(in_ready),
    .tp_wr_en(tp_wr_en), .tp_wr_addr(tp_wr_addr), .out_valid(out_valid),
    .out_ready(out_ready), .tp_rd_en(tp_rd_en), .tp_rd_addr(tp_rd_addr),
    .dc_en(dc_en), .out_last(out_last), .blk_cnt_in(blk_cnt_in),
    .blk_cnt_out(blk_cnt_out), .status(status)
`ifdef DCT_BLOCK_CTRL_STATS_EN
    , .stall_cnt(stall_cnt), .ovf_flag(ovf_flag)
`endif
  );

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    in_valid = 0; out_ready = 0; en = 1;
    reset = 0;
    step(); step();
    reset = 1;
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready got %b exp 1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid got %b exp 0", out_valid); end
    checks++; if (status !== 2'b00) begin errors++; $display("FAIL rst_status got %b exp 00", status); end
    checks++; if ({dc_en, out_last, tp_wr_en, tp_rd_en} !== 6'b0) begin errors++; $display("FAIL rst_strobes got %b exp 000000", {dc_en, out_last, tp_wr_en, tp_rd_en}); end
    checks++; if ({blk_cnt_in, blk_cnt_out} !== 30'd0) begin errors++; $display("FAIL rst_counters got %0d/%0d exp 0/0", blk_cnt_in, blk_cnt_out); end
    en = 0; #1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL rst_in_ready_en0 got %b exp 0", in_ready); end
    en = 1; #1;
  endtask

  // 16 rows streamed, reader always ready; cycle c = cycle after reset release
  task automatic test_stream();
    logic [1:0] ewr, erd, est;
    logic       eov, edc, ela;
    do_reset();
    out_ready = 1;
    for (int c = 0; c < 24; c++) begin
      in_valid = (c < 16);
      #1;
      ewr = (c < 8) ? 2'b01 : (c < 16) ? 2'b10 : 2'b00;
      eov = (c >= 8);
      erd = (c < 8) ? 2'b00 : (c < 16) ? 2'b01 : 2'b10;
      edc = (c == 8) || (c == 16);
      ela = (c == 15) || (c == 23);
      est = (c < 8) ? 2'b00 : 2'b01;
      checks++; if (tp_wr_en !== ewr) begin errors++; $display("FAIL stream_wr_en c=%0d got %b exp %b", c, tp_wr_en, ewr); end
      if (c < 16) begin
        checks++; if (tp_wr_addr !== 3'(c)) begin errors++; $display("FAIL stream_wr_addr c=%0d got %0d exp %0d", c, tp_wr_addr, c % 8); end
      end
      checks++; if (out_valid !== eov) begin errors++; $display("FAIL stream_out_valid c=%0d got %b exp %b", c, out_valid, eov); end
      checks++; if (tp_rd_en !== erd) begin errors++; $display("FAIL stream_rd_en c=%0d got %b exp %b", c, tp_rd_en, erd); end
      checks++; if ({dc_en, out_last} !== {edc, ela}) begin errors++; $display("FAIL stream_dc_last c=%0d got %b exp %b", c, {dc_en, out_last}, {edc, ela}); end
      checks++; if (status !== est) begin errors++; $display("FAIL stream_status c=%0d got %b exp %b", c, status, est); end
      if (c >= 8) begin
        checks++; if (tp_rd_addr !== 3'(c - 8)) begin errors++; $display("FAIL stream_rd_addr c=%0d got %0d exp %0d", c, tp_rd_addr, (c - 8) % 8); end
      end
      step();
    end
    in_valid = 0; #1;
    checks++; if (blk_cnt_out !== 15'd2) begin errors++; $display("FAIL stream_blk_out got %0d exp 2", blk_cnt_out); end
    checks++; if (blk_cnt_in !== 15'd2) begin errors++; $display("FAIL stream_blk_in got %0d exp 2", blk_cnt_in); end
    checks++; if (status !== 2'b00) begin errors++; $display("FAIL stream_status_end got %b exp 00", status); end
  endtask

  // Both banks fill under backpressure; a single final read frees the writer
  task automatic test_backpressure();
    do_reset();
    out_ready = 0;
    for (int c = 0; c < 20; c++) begin
      in_valid = 1; #1;
      checks++; if (in_ready !== (c < 16)) begin errors++; $display("FAIL bp_in_ready c=%0d got %b exp %b", c, in_ready, c < 16); end
      if (c >= 16) begin
        checks++; if ({status, out_valid, dc_en, tp_rd_addr, tp_rd_en} !== {2'b10, 1'b1, 1'b1, 3'd0, 2'b00})
          begin errors++; $display("FAIL bp_full_stall c=%0d got st=%b ov=%b dc=%b ra=%0d re=%b exp st=10 ov=1 dc=1 ra=0 re=00", c, status, out_valid, dc_en, tp_rd_addr, tp_rd_en); end
      end
      step();
    end
    in_valid = 0; out_ready = 1;
    for (int k = 0; k < 7; k++) step();
    out_ready = 0; #1;
    checks++; if ({out_last, dc_en, tp_rd_addr, in_ready} !== {1'b1, 1'b0, 3'd7, 1'b0})
      begin errors++; $display("FAIL bp_at_last got last=%b dc=%b ra=%0d ir=%b exp last=1 dc=0 ra=7 ir=0", out_last, dc_en, tp_rd_addr, in_ready); end
    step();
    checks++; if ({out_last, tp_rd_addr} !== {1'b1, 3'd7}) begin errors++; $display("FAIL bp_last_hold got last=%b ra=%0d exp last=1 ra=7", out_last, tp_rd_addr); end
    out_ready = 1; #1;
    checks++; if ({tp_rd_en, in_ready} !== {2'b01, 1'b0}) begin errors++; $display("FAIL bp_final_read got re=%b ir=%b exp re=01 ir=0", tp_rd_en, in_ready); end
    step();
    out_ready = 0; #1;
    checks++; if ({in_ready, status, out_valid, dc_en, tp_rd_addr} !== {1'b1, 2'b01, 1'b1, 1'b1, 3'd0})
      begin errors++; $display("FAIL bp_after_free got ir=%b st=%b ov=%b dc=%b ra=%0d exp ir=1 st=01 ov=1 dc=1 ra=0", in_ready, status, out_valid, dc_en, tp_rd_addr); end
    checks++; if (blk_cnt_out !== 15'd1) begin errors++; $display("FAIL bp_blk_out got %0d exp 1", blk_cnt_out); end
  endtask

  // 64 rows with reader toggling every cycle, checked against a row-count model
  task automatic test_toggle();
    int w, r, cyc, blocks;
    logic tog, eir, eov;
    logic [1:0] ewr, erd;
    do_reset();
    w = 0; r = 0; cyc = 0; tog = 1;
    while ((r < 64) && (cyc < 600)) begin
      in_valid = (w < 64); out_ready = tog; #1;
      blocks = (w / 8) - (r / 8);
      eir = (blocks < 2);
      eov = (blocks > 0);
      ewr = (in_valid && eir) ? (((w / 8) % 2 == 1) ? 2'b10 : 2'b01) : 2'b00;
      erd = (eov && tog) ? (((r / 8) % 2 == 1) ? 2'b10 : 2'b01) : 2'b00;
      checks++; if (in_ready !== eir) begin errors++; $display("FAIL tog_in_ready cyc=%0d got %b exp %b", cyc, in_ready, eir); end
      checks++; if (out_valid !== eov) begin errors++; $display("FAIL tog_out_valid cyc=%0d got %b exp %b", cyc, out_valid, eov); end
      checks++; if (tp_wr_en !== ewr) begin errors++; $display("FAIL tog_wr_en cyc=%0d got %b exp %b", cyc, tp_wr_en, ewr); end
      checks++; if (tp_rd_en !== erd) begin errors++; $display("FAIL tog_rd_en cyc=%0d got %b exp %b", cyc, tp_rd_en, erd); end
      checks++; if (tp_wr_addr !== 3'(w % 8)) begin errors++; $display("FAIL tog_wr_addr cyc=%0d got %0d exp %0d", cyc, tp_wr_addr, w % 8); end
      checks++; if (tp_rd_addr !== 3'(r % 8)) begin errors++; $display("FAIL tog_rd_addr cyc=%0d got %0d exp %0d", cyc, tp_rd_addr, r % 8); end
      if (ewr != 2'b00) w++;
      if (erd != 2'b00) r++;
      step();
      tog = ~tog; cyc++;
    end
    in_valid = 0; out_ready = 0; #1;
    checks++; if (cyc >= 600) begin errors++; $display("FAIL tog_timeout got %0d reads exp 64", r); end
    checks++; if ({blk_cnt_in, blk_cnt_out} !== {15'd8, 15'd8}) begin errors++; $display("FAIL tog_counts got %0d/%0d exp 8/8", blk_cnt_in, blk_cnt_out); end
    checks++; if (status !== 2'b00) begin errors++; $display("FAIL tog_status got %b exp 00", status); end
  endtask

  // Enable gap after 3 rows: partial block kept, writing resumes at row 3
  task automatic test_en_gap();
    do_reset();
    out_ready = 1; in_valid = 1;
    for (int k = 0; k < 3; k++) step();
    en = 0;
    for (int k = 0; k < 5; k++) begin
      #1;
      checks++; if ({in_ready, tp_wr_en, tp_wr_addr} !== {1'b0, 2'b00, 3'd3}) begin errors++; $display("FAIL gap_hold k=%0d got ir=%b we=%b wa=%0d exp ir=0 we=00 wa=3", k, in_ready, tp_wr_en, tp_wr_addr); end
      step();
    end
    en = 1;
    for (int k = 0; k < 5; k++) begin
      #1;
      checks++; if ({tp_wr_en, tp_wr_addr, out_valid} !== {2'b01, 3'(3 + k), 1'b0}) begin errors++; $display("FAIL gap_resume k=%0d got we=%b wa=%0d ov=%b exp we=01 wa=%0d ov=0", k, tp_wr_en, tp_wr_addr, out_valid, 3 + k); end
      step();
    end
    in_valid = 0; out_ready = 0; #1;
    checks++; if ({out_valid, blk_cnt_in} !== {1'b1, 15'd1}) begin errors++; $display("FAIL gap_done got ov=%b bi=%0d exp ov=1 bi=1", out_valid, blk_cnt_in); end
  endtask

  // Asynchronous reset with one bank full and the other at row 5
  task automatic test_reset_mid();
    do_reset();
    in_valid = 1;
    for (int k = 0; k < 13; k++) step();
    in_valid = 0; #1;
    checks++; if ({tp_wr_addr, status, out_valid, blk_cnt_in} !== {3'd5, 2'b01, 1'b1, 15'd1}) begin errors++; $display("FAIL mid_pre got wa=%0d st=%b ov=%b bi=%0d exp wa=5 st=01 ov=1 bi=1", tp_wr_addr, status, out_valid, blk_cnt_in); end
    reset = 0; #1;
    checks++; if ({in_ready, out_valid, dc_en, out_last, tp_wr_en, tp_rd_en, status} !== {1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00})
      begin errors++; $display("FAIL mid_async got ir=%b ov=%b dc=%b ol=%b we=%b re=%b st=%b exp ir=1 rest 0", in_ready, out_valid, dc_en, out_last, tp_wr_en, tp_rd_en, status); end
    checks++; if ({blk_cnt_in, blk_cnt_out, tp_wr_addr} !== 33'd0) begin errors++; $display("FAIL mid_counters got bi=%0d bo=%0d wa=%0d exp 0", blk_cnt_in, blk_cnt_out, tp_wr_addr); end
    step();
    reset = 1; #1;
    in_valid = 1; #1;
    checks++; if ({tp_wr_en, tp_wr_addr} !== {2'b01, 3'd0}) begin errors++; $display("FAIL mid_restart got we=%b wa=%0d exp we=01 wa=0", tp_wr_en, tp_wr_addr); end
    in_valid = 0;
  endtask

`ifdef DCT_BLOCK_CTRL_STATS_EN
  task automatic test_stats();
    do_reset();
    in_valid = 1; out_ready = 0;
    for (int k = 0; k < 8; k++) step();
    in_valid = 0; #1;
    checks++; if (stall_cnt !== 16'd0) begin errors++; $display("FAIL stats_stall_pre got %0d exp 0", stall_cnt); end
    for (int k = 0; k < 10; k++) step();
    checks++; if (stall_cnt !== 16'd10) begin errors++; $display("FAIL stats_stall got %0d exp 10", stall_cnt); end
    in_valid = 1;
    for (int k = 0; k < 8; k++) step();
    checks++; if ({ovf_flag, in_ready} !== 2'b00) begin errors++; $display("FAIL stats_ovf_pre got ovf=%b ir=%b exp 0/0", ovf_flag, in_ready); end
    step();
    in_valid = 0;
    for (int k = 0; k < 3; k++) step();
    checks++; if (ovf_flag !== 1'b1) begin errors++; $display("FAIL stats_ovf got %b exp 1", ovf_flag); end
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    reset = 0; en = 1; in_valid = 0; out_ready = 0;
    test_reset();
    test_stream();
    test_backpressure();
    test_toggle();
    test_en_gap();
    test_reset_mid();
`ifdef DCT_BLOCK_CTRL_STATS_EN
    test_stats();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
